// File: rtl/dds_voice_bank.sv
// rtl/dds_voice_bank.sv - time-multiplexed bank of DDS sine voices mixed into one signed sample per tick
module dds_voice_bank #(
    parameter int CHANNELS    = 4,
    parameter int FPMULT      = 65536,
    parameter int SINEROMSIZE = 1024,
    parameter int OUT_W       = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      sample_tick,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [$clog2(CHANNELS)-1:0]               cfg_chan,
    input  logic [15:0]                               cfg_step,
    input  logic [3:0]                                cfg_shift,
    input  logic                                      cfg_enable,
    input  logic                                      cfg_sync,
    output logic signed [OUT_W+$clog2(CHANNELS)-1:0]  sample_out,
    output logic                                      sample_valid,
    output logic                                      overrun
);

    localparam int CH_W    = $clog2(CHANNELS);
    localparam int FRAC_W  = $clog2(FPMULT);
    localparam int ADDR_W  = $clog2(SINEROMSIZE);
    localparam int ACC_W   = FRAC_W + ADDR_W;
    localparam int MIX_W   = OUT_W + CH_W;
    localparam int QUARTER = SINEROMSIZE / 4;
    localparam int MAG_MAX = 2 ** (OUT_W - 1) - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Half-step-offset quarter sine (Bhaskara rational form) so the ~index fold is symmetric.
    function automatic logic [OUT_W-2:0] quarter_sine(input int idx);
        logic [63:0] x, p, num, den;
        x   = 64'(2 * idx + 1);
        p   = x * (64'(SINEROMSIZE) - x);
        num = 64'(MAG_MAX) * 64'd16 * p;
        den = 64'd5 * 64'(SINEROMSIZE) * 64'(SINEROMSIZE) - 64'd4 * p;
        quarter_sine = (OUT_W-1)'((num + (den >> 1)) / den);
    endfunction

    logic [OUT_W-2:0] rom [QUARTER];

    for (genvar g = 0; g < QUARTER; g++) begin : g_rom
        assign rom[g] = quarter_sine(g);
    end

    state_t            state;
    logic [CH_W-1:0]   issue_chan;
    logic              drain_cnt;
    logic [ACC_W-1:0]  acc    [CHANNELS];
    logic [15:0]       step   [CHANNELS];
    logic [3:0]        shift  [CHANNELS];
    logic [CHANNELS-1:0] enable;

    logic              s1_valid, s1_first, s1_last, s1_neg, s1_en;
    logic [ADDR_W-3:0] s1_index;
    logic [3:0]        s1_shift;

    logic              s2_valid, s2_first, s2_last, s2_neg, s2_en;
    logic [OUT_W-2:0]  rom_q;
    logic [3:0]        s2_shift;

    logic signed [MIX_W-1:0] mix;
    logic                    done;

    logic                    cfg_write;
    logic [ADDR_W-1:0]       issue_addr;
    logic signed [OUT_W-1:0] voice_val;
    logic signed [MIX_W-1:0] voice_ext;
    logic signed [MIX_W-1:0] contrib;

    assign cfg_ready  = (state == IDLE) && !reset;
    assign cfg_write  = cfg_valid && cfg_ready;
    assign issue_addr = acc[issue_chan][ACC_W-1 -: ADDR_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            issue_chan <= '0;
            drain_cnt  <= 1'b0;
            overrun    <= 1'b0;
            enable     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i]   <= '0;
                step[i]  <= '0;
                shift[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state      <= RUN;
                        issue_chan <= '0;
                    end
                end
                RUN: begin
                    if (issue_chan == CH_W'(CHANNELS - 1)) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        issue_chan <= issue_chan + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) state <= IDLE;
                    drain_cnt <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            if (sample_tick && state != IDLE) overrun <= 1'b1;

            // Writes land only in IDLE and issues only in RUN, so they never collide on acc.
            if (cfg_write) begin
                step[cfg_chan]   <= cfg_step;
                shift[cfg_chan]  <= cfg_shift;
                enable[cfg_chan] <= cfg_enable;
                if (cfg_sync) acc[cfg_chan] <= '0;
            end

            if (state == RUN && enable[issue_chan])
                acc[issue_chan] <= acc[issue_chan] + ACC_W'(step[issue_chan]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_neg   <= 1'b0;
            s1_en    <= 1'b0;
            s1_index <= '0;
            s1_shift <= '0;
        end else begin
            s1_valid <= (state == RUN);
            s1_first <= (issue_chan == '0);
            s1_last  <= (issue_chan == CH_W'(CHANNELS - 1));
            s1_neg   <= issue_addr[ADDR_W-1];
            s1_en    <= enable[issue_chan];
            s1_index <= issue_addr[ADDR_W-2] ? ~issue_addr[ADDR_W-3:0] : issue_addr[ADDR_W-3:0];
            s1_shift <= shift[issue_chan];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_neg   <= 1'b0;
            s2_en    <= 1'b0;
            s2_shift <= '0;
            rom_q    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_neg   <= s1_neg;
            s2_en    <= s1_en;
            s2_shift <= s1_shift;
            rom_q    <= rom[s1_index];
        end
    end

    always_comb begin
        voice_val = s2_neg ? ~{1'b0, rom_q} : {1'b0, rom_q};
        voice_ext = {{(MIX_W - OUT_W){voice_val[OUT_W-1]}}, voice_val};
        contrib   = '0;
        if (s2_en) contrib = voice_ext >>> s2_shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mix          <= '0;
            done         <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            if (s2_valid) mix <= (s2_first ? MIX_W'(0) : mix) + contrib;
            done         <= s2_valid && s2_last;
            sample_valid <= done;
            if (done) sample_out <= mix;
        end
    end

endmodule

// File: tb/tb_dds_voice_bank.sv
// tb/tb_dds_voice_bank.sv - directed self-checking bench for dds_voice_bank
module tb_dds_voice_bank;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_tick;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_chan;
    logic [15:0]        cfg_step;
    logic [3:0]         cfg_shift;
    logic               cfg_enable;
    logic               cfg_sync;
    logic signed [17:0] sample_out;
    logic               sample_valid;
    logic               overrun;

    int checks   = 0;
    int failures = 0;

    dds_voice_bank dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_chan     (cfg_chan),
        .cfg_step     (cfg_step),
        .cfg_shift    (cfg_shift),
        .cfg_enable   (cfg_enable),
        .cfg_sync     (cfg_sync),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic set_cfg(input logic [1:0] ch, input logic [15:0] st, input logic [3:0] sh,
                           input logic en, input logic sy);
        cfg_chan   = ch;
        cfg_step   = st;
        cfg_shift  = sh;
        cfg_enable = en;
        cfg_sync   = sy;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] st, input logic [3:0] sh,
                             input logic en, input logic sy);
        @(negedge clk);
        set_cfg(ch, st, sh, en, sy);
        cfg_valid = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    // Pulses a tick (optionally with a coincident write) and waits, bounded, for the strobe.
    task automatic tick_wait(input bit with_cfg, output logic signed [17:0] s, output int lat);
        @(negedge clk);
        sample_tick = 1'b1;
        cfg_valid   = with_cfg;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        cfg_valid   = 1'b0;
        lat = 0;
        s   = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (sample_valid) begin
                lat = c;
                s   = sample_out;
                break;
            end
        end
    endtask

    logic signed [17:0] s;
    int lat;
    int vcnt;
    int acc_edge;
    logic ready_mid;

    initial begin
        reset = 1'b1;
        sample_tick = 1'b0;
        cfg_valid = 1'b0;
        set_cfg(2'd0, 16'd0, 4'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", 32'(cfg_ready), 0);
        check("rst_sample_out", 32'(sample_out), 0);
        check("rst_sample_valid", 32'(sample_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset = 1'b0;
        #1;
        check("idle_cfg_ready", 32'(cfg_ready), 1);

        tick_wait(0, s, lat);
        check("first_latency", 32'(lat), 7);
        check("first_sample_zero", 32'($signed(s)), 0);
        check("first_overrun", 32'(overrun), 0);

        set_cfg(2'd0, 16'd0, 4'd1, 1'b1, 1'b1);
        tick_wait(1, s, lat);
        check("coincident_latency", 32'(lat), 7);
        check("coincident_new_cfg", 32'($signed(s)), 51);

        cfg_write(2'd0, 16'hFFFF, 4'd0, 1'b1, 1'b1);
        for (int k = 0; k <= 769; k++) begin
            if (k == 769) cfg_write(2'd0, 16'hFFFF, 4'd3, 1'b1, 1'b0);
            tick_wait(0, s, lat);
            case (k)
                0:   check("v0_addr0", 32'($signed(s)), 102);
                1:   check("v0_addr0_frac_loss", 32'($signed(s)), 102);
                256: check("v0_addr255_peak", 32'($signed(s)), 32767);
                257: check("v0_addr256_peak", 32'($signed(s)), 32767);
                512: check("v0_addr511", 32'($signed(s)), 102);
                513: check("v0_addr512_neg", 32'($signed(s)), -103);
                769: check("v0_addr768_shift3", 32'($signed(s)), -4096);
                default: ;
            endcase
        end

        for (int v = 0; v < 4; v++) cfg_write(2'(v), 16'hFFFF, 4'd2, 1'b1, 1'b1);
        for (int j = 0; j <= 256; j++) begin
            tick_wait(0, s, lat);
            if (j == 0)   check("all4_addr0_shift2", 32'($signed(s)), 100);
            if (j == 256) check("all4_peak_shift2", 32'($signed(s)), 32764);
        end

        check("pre_overrun", 32'(overrun), 0);
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        vcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (sample_valid) vcnt++;
            sample_tick = (c == 2);
        end
        check("overrun_single_strobe", 32'(vcnt), 1);
        check("overrun_set", 32'(overrun), 1);
        tick_wait(0, s, lat);
        check("overrun_sticky", 32'(overrun), 1);

        for (int v = 1; v < 4; v++) cfg_write(2'(v), 16'd0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        set_cfg(2'd0, 16'd0, 4'd0, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        acc_edge  = 0;
        ready_mid = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 3) ready_mid = cfg_ready;
            if (cfg_ready) begin
                acc_edge = c;
                @(posedge clk);
                #1 cfg_valid = 1'b0;
                break;
            end
            @(posedge clk);
        end
        cfg_valid = 1'b0;
        check("held_ready_during_run", 32'(ready_mid), 0);
        check("held_accept_edge", 32'(acc_edge), 7);
        tick_wait(0, s, lat);
        check("held_write_applied", 32'($signed(s)), 102);

        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sample_tick = 1'b0;
        vcnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (sample_valid) vcnt++;
        end
        check("abort_no_strobe", 32'(vcnt), 0);
        check("abort_sample_out", 32'($signed(sample_out)), 0);
        check("abort_overrun_clear", 32'(overrun), 0);
        check("abort_cfg_ready", 32'(cfg_ready), 1);
        tick_wait(0, s, lat);
        check("post_reset_latency", 32'(lat), 7);
        check("post_reset_sample", 32'($signed(s)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_voice_bank.md
DDS_VOICE_BANK -- requirements
Module: dds_voice_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of time-multiplexed oscillator voices, power of two, 2..16.
REQ-002 SHALL have parameter FPMULT, default 65536: fixed-point fraction scale of each phase accumulator (FRAC_W = log2(FPMULT)).
REQ-003 SHALL have parameter SINEROMSIZE, default 1024: steps per full sine cycle (ADDR_W = log2). The quarter table holds SINEROMSIZE/4 entries.
REQ-004 SHALL have parameter OUT_W, default 16: per-voice sample width; mix width MIX_W = OUT_W + log2(CHANNELS).
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 sample_tick  in  1  one-cycle pulse requesting one mixed output sample.
REQ-008 cfg_valid  in  1  configuration write request.
REQ-009 cfg_ready  out  1  configuration write can be accepted.
REQ-010 cfg_chan  in  log2(CHANNELS)  target voice.
REQ-011 cfg_step  in  16  phase increment per sample, unsigned fixed point.
REQ-012 cfg_shift  in  4  attenuation; the voice sample is arithmetically right-shifted by this amount.
REQ-013 cfg_enable  in  1  voice enable.
REQ-014 cfg_sync  in  1  clears the voice phase accumulator on write.
REQ-015 sample_out  out  MIX_W  signed sum of all voices.
REQ-016 sample_valid  out  1  one-cycle strobe; sample_out is new.
REQ-017 overrun  out  1  sticky flag; a tick arrived while busy.

Function
REQ-018 Per voice, SHALL hold: phase accumulator (FRAC_W+ADDR_W bits, wraps modulo 2^width), step, shift, enable.
REQ-019 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE -> RUN: on sample_tick.
  - RUN: issues voices 0..CHANNELS-1, one per cycle, ascending; exits after voice CHANNELS-1.
  - DRAIN: lasts 2 cycles, then IDLE.
REQ-020 For each issued voice: lookup address = accumulator[FRAC_W+ADDR_W-1:FRAC_W] using the pre-increment value; accumulator <= accumulator + step in the same cycle. Only enabled voices advance.
REQ-021 Pipeline: issue cycle -> quarter ROM read (registered, 1 cycle) -> fold/shift/accumulate (1 cycle).
REQ-022 Quadrant fold:
  - ROM index = addr[ADDR_W-3:0], bitwise-inverted when addr[ADDR_W-2]=1.
  - Voice value = +mag when addr[ADDR_W-1]=0; otherwise ~mag (ones' complement).
  - The ROM holds unsigned magnitudes 0..2^(OUT_W-1)-1.
REQ-023 Voice value SHALL be sign-extended to MIX_W, then arithmetically right-shifted by shift. A disabled voice contributes exactly 0.
REQ-024 The mix accumulator SHALL clear at the first voice of each run. The sum never overflows by construction of MIX_W.
REQ-025 sample_valid SHALL assert exactly CHANNELS+3 cycles after the cycle sample_tick is sampled in IDLE, for one cycle. sample_out SHALL update in that cycle and hold until the next strobe.
REQ-026 cfg_ready = 1 only in IDLE and not in reset. A write occurs when cfg_valid & cfg_ready. Registers update at that edge.
REQ-027 cfg_sync=1 with a write SHALL set that voice's accumulator to 0. cfg_sync=0 leaves the phase untouched.
REQ-028 If a write and sample_tick coincide in IDLE, both SHALL be accepted. The run uses the newly written values.
REQ-029 sample_tick outside IDLE SHALL be ignored and SHALL set overrun. overrun clears only on reset.
REQ-030 cfg_valid while cfg_ready=0 SHALL have no effect. The source must hold it.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL apply all of:
  - state IDLE; all accumulators, steps, shifts and enables = 0;
  - sample_out = 0, sample_valid = 0, overrun = 0, cfg_ready = 0;
  - pipeline contents discarded.
REQ-032 Reset asserted mid-RUN/DRAIN SHALL abort the run with no sample_valid. Ticks during reset are ignored and do not set overrun.

Verification
REQ-033 Reset, then tick at cycle T: sample_valid at T+7 (CHANNELS=4), sample_out = 0, overrun = 0.
REQ-034 Voice 0: enable=1, step=0xFFFF, shift=0, sync=1; others disabled; 257 ticks. The address advances by 1 per tick minus the fractional loss. Sample peaks near +32767 around tick 256. The sign flips after address 512.
REQ-035 All 4 voices enabled with identical step, shift=2, phase at quarter peak: sample_out = 4 * (mag >> 2).
REQ-036 Tick again at T+3 during RUN: ignored; overrun = 1 and stays 1 until reset; exactly one sample_valid is produced.
REQ-037 cfg_valid held through a run: cfg_ready=0 until IDLE, write accepted on the first IDLE cycle. Coincident write+tick: the new step is used in that run.
REQ-038 Reset pulsed at T+4 of a run: no sample_valid, all outputs 0. The next tick yields sample_out = 0.
